// File: rtl/regwb_pkg.sv
// Shared types and helpers for the register-file write-back controller.
package regwb_pkg;

  localparam int unsigned WB_BITS = 32;
  localparam int unsigned RD_W    = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic               valid;
    logic [RD_W-1:0]    rd;
    logic [WB_BITS-1:0] data;
  } wb_entry_t;

  // Select the addressed byte/half of an aligned word and extend it to full width.
  function automatic logic [WB_BITS-1:0] load_extend(input logic [2:0]         funct3,
                                                     input logic [1:0]         offset,
                                                     input logic [WB_BITS-1:0] word);
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    w_byte = word[{offset, 3'b000} +: 8];
    w_half = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   load_extend = {{(WB_BITS-8){w_byte[7]}}, w_byte};
      F3_LBU:  load_extend = {{(WB_BITS-8){1'b0}}, w_byte};
      F3_LH:   load_extend = {{(WB_BITS-16){w_half[15]}}, w_half};
      F3_LHU:  load_extend = {{(WB_BITS-16){1'b0}}, w_half};
      F3_LW:   load_extend = word;
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/regwb_queue.sv
// In-order ALU result queue with per-entry valid bits, rd-match invalidate,
// pending-destination mask and occupancy count.
module regwb_queue
  import regwb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_push,
  input  wb_entry_t               i_push_entry,
  input  logic                    i_pop,
  input  logic                    i_inv,
  input  logic [RD_W-1:0]         i_inv_rd,
  output wb_entry_t               o_head_c,
  output logic                    o_full_c,
  output logic                    o_empty_c,
  output logic [31:0]             o_busy_mask_c,
  output logic [$clog2(DEPTH):0]  o_fifo_count_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]   r_valid;
  logic [RD_W-1:0]    r_rd   [DEPTH];
  logic [WB_BITS-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;

  logic w_push;
  logic w_pop;

  assign o_full_c       = (r_count == CNT_W'(DEPTH));
  assign o_empty_c      = (r_count == '0);
  assign o_fifo_count_c = r_count;
  assign w_push         = i_push && !o_full_c;
  assign w_pop          = i_pop && !o_empty_c;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_valid <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      // Supersede older writes to the load's destination; a same-cycle push is younger.
      for (int i = 0; i < DEPTH; i++) begin
        if (i_inv && r_valid[PTR_W'(i)] && (r_rd[PTR_W'(i)] == i_inv_rd))
          r_valid[PTR_W'(i)] <= 1'b0;
      end
      if (w_pop) begin
        r_valid[r_rptr] <= 1'b0;
        r_rptr          <= r_rptr + 1'b1;
      end
      if (w_push) begin
        r_valid[r_wptr] <= i_push_entry.valid;
        r_rd[r_wptr]    <= i_push_entry.rd;
        r_data[r_wptr]  <= i_push_entry.data;
        r_wptr          <= r_wptr + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_comb begin
    o_head_c       = '0;
    o_head_c.valid = r_valid[r_rptr] && !o_empty_c;
    o_head_c.rd    = r_rd[r_rptr];
    o_head_c.data  = r_data[r_rptr];
  end

  always_comb begin
    o_busy_mask_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[PTR_W'(i)]) o_busy_mask_c[r_rd[PTR_W'(i)]] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_writeback_ctrl.sv
// Register-file write-port controller: loads win, ALU results drain in order.
// Optional REGWB_BYPASS_EN sends an ALU result straight out when idle.
module regfile_writeback_ctrl
  import regwb_pkg::*;
#(
  parameter int unsigned BITS  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [4:0]              alu_rd,
  input  logic [BITS-1:0]         alu_data,
  input  logic                    ld_valid,
  input  logic [4:0]              ld_rd,
  input  logic [2:0]              ld_funct3,
  input  logic [1:0]              ld_offset,
  input  logic [BITS-1:0]         ld_data,
  output logic                    write,
  output logic [4:0]              writeaddr,
  output logic [BITS-1:0]         writedata,
  output logic [31:0]             busy_mask,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  wb_entry_t          w_head;
  wb_entry_t          w_push_entry;
  logic               w_full;
  logic               w_empty;
  logic               w_alu_acc;
  logic               w_pop;
  logic               w_push;
  logic               w_bypass;
  logic               w_ld_inv;
  logic [WB_BITS-1:0] w_ld_ext;

  assign alu_ready = !w_full;
  // rd 0 results are accepted but never occupy a slot.
  assign w_alu_acc = alu_valid && alu_ready && (alu_rd != '0);
  assign w_pop     = !ld_valid && !w_empty;
  assign w_ld_inv  = ld_valid && (ld_rd != '0);
  assign w_ld_ext  = load_extend(ld_funct3, ld_offset, WB_BITS'(ld_data));

`ifdef REGWB_BYPASS_EN
  assign w_bypass = w_alu_acc && w_empty && !ld_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_alu_acc && !w_bypass;

  always_comb begin
    w_push_entry       = '0;
    w_push_entry.valid = 1'b1;
    w_push_entry.rd    = alu_rd;
    w_push_entry.data  = WB_BITS'(alu_data);
  end

  regwb_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk            (clk),
    .rstn           (rstn),
    .i_push         (w_push),
    .i_push_entry   (w_push_entry),
    .i_pop          (w_pop),
    .i_inv          (w_ld_inv),
    .i_inv_rd       (ld_rd),
    .o_head_c       (w_head),
    .o_full_c       (w_full),
    .o_empty_c      (w_empty),
    .o_busy_mask_c  (busy_mask),
    .o_fifo_count_c (fifo_count)
  );

  // One write per cycle: load first, then bypass (only when idle), then queue head.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      write     <= 1'b0;
      writeaddr <= '0;
      writedata <= '0;
    end else begin
      write <= 1'b0;
      if (ld_valid) begin
        write     <= (ld_rd != '0);
        writeaddr <= ld_rd;
        writedata <= BITS'(w_ld_ext);
      end else if (w_bypass) begin
        write     <= 1'b1;
        writeaddr <= alu_rd;
        writedata <= alu_data;
      end else if (w_pop) begin
        write     <= w_head.valid;
        writeaddr <= w_head.rd;
        writedata <= BITS'(w_head.data);
      end
    end
  end

endmodule

// File: doc/regfile_writeback_ctrl.md
# regfile_writeback_ctrl

Write-side controller for the ID-stage register file: collects ALU results and load results, sign/zero-extends load data, orders them, and drives the register file's single write port (`write`, `writeaddr`, `writedata`). ALU results are buffered in a small in-order queue; load results are never stalled. A pending-destination mask goes to hazard detection in ID.

## Interface

Parameters:
- `BITS`, 32: data width.
- `DEPTH`, 4: ALU queue entries; power of two, ≥2.

Ports:
- `clk`, input, 1: clock.
- `rstn`, input, 1: reset, synchronous, active-low.
- `alu_valid`, input, 1: ALU result offered.
- `alu_ready`, output, 1: queue can accept.
- `alu_rd`, input, 5: ALU destination register.
- `alu_data`, input, BITS: ALU result.
- `ld_valid`, input, 1: load result present; always accepted, no back-pressure.
- `ld_rd`, input, 5: load destination register.
- `ld_funct3`, input, 3: load type.
- `ld_offset`, input, 2: byte address bits [1:0].
- `ld_data`, input, BITS: raw aligned memory word.
- `write`, output, 1: register file write enable.
- `writeaddr`, output, 5: register file write address.
- `writedata`, output, BITS: register file write data.
- `busy_mask`, output, 32: bit r set while a queued write to xr is pending.
- `fifo_count`, output, $clog2(DEPTH)+1: number of valid queue entries.

## Operation

ALU acceptance:
- Accepted when `alu_valid && alu_ready`.
- `alu_ready = !full`. It is based on occupancy only; no pop-through when the queue is full.
- `alu_rd == 0` is accepted and discarded, with no queue entry.

Load path:
- A load is accepted every cycle `ld_valid` is high.
- `ld_rd == 0` is discarded.

Load extension, by `ld_funct3`:
- 000 LB: byte selected by `ld_offset`, sign-extended.
- 100 LBU: same byte, zero-extended.
- 001 LH: half selected by `ld_offset[1]`, sign-extended.
- 101 LHU: same half, zero-extended.
- 010 LW, and any other code: word passed unchanged.

Arbitration, once per cycle, one write:
- A valid load wins.
- Otherwise, the queue head pops if valid.
- Otherwise, `write` = 0.

Ordering:
- A load is always younger than every queued ALU result.
- On an accepted load with nonzero `ld_rd`, every queued entry with the same rd is invalidated (superseded).
- Invalidated entries are dropped silently on pop and do not drive `write`.
- An ALU result accepted in the same cycle as a matching load is younger than the load and is not invalidated.

Busy mask and count:
- `busy_mask` is the OR of the rd one-hots of valid queue entries, combinational from queue state.
- `fifo_count` counts allocated slots, including invalidated slots not yet popped.

Reset (also mid-operation):
- Queue flushed.
- `write`, `writeaddr`, `writedata` = 0.
- `busy_mask` = 0, `fifo_count` = 0.
- `alu_ready` = 1 in the cycle after reset is released.

## Timing

- All write-port outputs are registered.
- Load accepted in cycle N: write visible in cycle N+1.
- ALU accepted in cycle N through the queue: earliest write in cycle N+2; each cycle with a valid load adds one cycle of delay.
- Queue push and pop in the same cycle leave `fifo_count` unchanged.
- The queue pointers wrap modulo DEPTH.
- `write` is a single-cycle pulse per committed result. Back-to-back writes are allowed every cycle.

## Configuration

- `REGWB_BYPASS_EN` defined:
  - When the queue is empty, no load is valid, and an ALU result is accepted, that result goes straight to the output registers without being queued.
  - Write visible in cycle N+1.
  - `busy_mask` is never set for it.
- Macro undefined: every accepted ALU result enters the queue (N+2 minimum latency).

## Structure

- Package `regwb_pkg`:
  - funct3 constants `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`.
  - typedef `wb_entry_t` {valid, rd[4:0], data[BITS-1:0]}.
  - function `load_extend(funct3, offset, word)`.
- Sub-module `regwb_queue`: circular DEPTH-entry buffer with per-entry valid bits. Provides push/pop, rd-match invalidate, and `busy_mask`/`fifo_count` outputs.
- The top level holds arbitration, bypass, and the output registers.

## Test plan

1. Reset with the queue holding 3 entries → next cycle `fifo_count`=0, `busy_mask`=0, `write`=0, `alu_ready`=1.
2. ALU rd=5, data=0x1234 into an empty queue, bypass undefined → `busy_mask`[5]=1 for one cycle, then `write`=1, `writeaddr`=5, `writedata`=0x1234 two cycles after accept. With `REGWB_BYPASS_EN`: write one cycle after accept, `busy_mask` stays 0.
3. Load `ld_data`=0x80F1_7F02:
   - LB, offset 3 → 0xFFFF_FF80.
   - LBU, offset 3 → 0x0000_0080.
   - LH, offset 2 → 0xFFFF_80F1.
   - LHU, offset 0 → 0x0000_7F02.
   - LW → unchanged.
4. Queue holds rd=7 (0xAA) and rd=8 (0xBB); load rd=7, data 0xCC arrives → write x7=0xCC next cycle. x7=0xAA never written. x8=0xBB written afterwards. `busy_mask`[7] clears the cycle after the load.
5. Hold `alu_valid` with distinct rd values and no loads → `alu_ready` drops at `fifo_count`=DEPTH. All DEPTH+k writes appear in acceptance order across pointer wrap.
6. ALU and load both to rd=0 → no write pulses, `fifo_count` stays 0.
